nano_fetch_ctrl: RTL and testbench
==================================

// Module: nano_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the nano_riscv core. Owns the fetch PC, drives a
//  single-outstanding req/ack instruction-memory port, buffers returned words in a
//  small FIFO and presents them to the decode stage (i_inst) with valid/ready.
//  Handles core redirects (branch/jump) by flushing the buffer and squashing in-flight fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset; must be 4-byte aligned
//  BUF_DEPTH  2              instruction FIFO entries; power of 2, 2..8
// PORTS
//  i_clk           in   1   clock, all state on rising edge
//  i_rst           in   1   reset, synchronous, active-low (0 = reset)
//  o_imem_req      out  1   fetch request; held high until i_imem_ack
//  o_imem_addr     out  32  fetch byte address; stable while o_imem_req high
//  i_imem_ack      in   1   request complete; i_imem_rdata valid this cycle
//  i_imem_rdata    in   32  fetched instruction word
//  o_inst_valid    out  1   o_inst/o_inst_pc hold a valid instruction
//  o_inst          out  32  instruction to decode (FIFO head)
//  o_inst_pc       out  32  address of o_inst
//  i_inst_ready    in   1   decode accepts head this cycle
//  i_redirect      in   1   redirect fetch stream (one-cycle pulse)
//  i_redirect_pc   in   32  redirect target
//  o_fetch_err     out  1   sticky: misaligned redirect target seen
// BEHAVIOUR
//  Reset (i_rst==0 at edge): state FETCH, fetch_pc=RESET_PC, FIFO empty, outstanding=0;
//   o_imem_req=0, o_imem_addr=RESET_PC, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_fetch_err=0.
//   Reset mid-transaction abandons the outstanding request; imem shares i_rst.
//  Handshakes: imem xfer = req&ack; decode xfer = o_inst_valid&i_inst_ready.
//   i_imem_ack while o_imem_req==0 is ignored. Max one outstanding request.
//  Credit: new request issued only if fifo_count + outstanding < BUF_DEPTH
//   (fifo_count is the registered value; a pop in the current cycle frees credit next cycle).
//  FSM states:
//   FETCH: req=credit ok; addr=fetch_pc. On ack: push {rdata, fetch_pc}, fetch_pc+=4.
//    Req may stay high across ack with next addr -> 1 instr/cycle with 1-cycle-ack memory.
//   DRAIN: abandoned request in flight; req and addr held at old values until ack;
//    data discarded; next state FETCH at the redirect target.
//   HALT: entered on misaligned redirect; completes any in-flight request (discarded),
//    then req=0 permanently; o_inst_valid=0. Exit only via reset.
//  Redirect (i_redirect=1, state FETCH/DRAIN):
//   - FIFO flushed at the edge; o_inst_valid=0 next cycle. A decode xfer in the same
//     cycle still counts as consumed by decode.
//   - target[1:0]!=0: o_fetch_err=1 next cycle, -> HALT.
//   - else fetch_pc<=target; if req high and no ack this cycle -> DRAIN;
//     if ack this cycle, data discarded (no push), -> FETCH; if no req -> FETCH.
//   - Redirect while in DRAIN replaces stored target; stays DRAIN.
//   - Redirect in HALT ignored.
//  Latency: ack at cycle N -> o_inst_valid=1 at N+1 (if FIFO was empty);
//   redirect at cycle N -> o_imem_req with new addr at N+1 (FETCH) or cycle after drain ack.
//  FIFO: push and pop in the same cycle allowed, count unchanged; overflow impossible by
//   credit rule; pop when empty impossible (valid=0). Pointers wrap modulo BUF_DEPTH.
//  fetch_pc arithmetic is 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
// TESTING
//  1 Reset release, ack every cycle, ready=1 -> addrs 0,4,8,..; o_inst_valid from 2nd cycle,
//    one instr/cycle, o_inst_pc matches addr.
//  2 ready=0 with ack always high -> exactly BUF_DEPTH pushes then req=0; ready=1 -> resume,
//    order preserved, no loss or duplicate.
//  3 Ack delayed 3 cycles, redirect to 0x100 on cycle 1 -> req/addr held at old addr until
//    ack, that data dropped, next req addr=0x100, first o_inst_pc=0x100.
//  4 Redirect to 0x200 in same cycle as ack of 0x8 -> 0x8 never valid; next addr 0x200.
//  5 Redirect to 0x102 -> o_fetch_err=1 next cycle, o_inst_valid=0, req=0 after in-flight
//    ack; later redirects ignored; reset clears err and restarts at RESET_PC.
//  6 Reset asserted with req outstanding -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/nano_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// nano_fetch_ctrl
//   Instruction-fetch sequencer for the nano_riscv core. Owns the fetch PC,
//   runs a single-outstanding req/ack port towards instruction memory, buffers
//   returned words in a small FIFO and hands them to decode with valid/ready.
//   A core redirect flushes the buffer and squashes any in-flight fetch; a
//   misaligned redirect target parks the sequencer in HALT until reset.
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_rst          synchronous reset, active low
//   o_imem_req     fetch request, held high until i_imem_ack
//   o_imem_addr    fetch byte address, stable while o_imem_req is high
//   i_imem_ack     request complete, i_imem_rdata valid this cycle
//   i_imem_rdata   fetched instruction word
//   o_inst_valid   o_inst / o_inst_pc hold a valid instruction (FIFO head)
//   o_inst         instruction to decode
//   o_inst_pc      address of o_inst
//   i_inst_ready   decode accepts the head this cycle
//   i_redirect     redirect the fetch stream (one-cycle pulse)
//   i_redirect_pc  redirect target
//   o_fetch_err    sticky flag: misaligned redirect target seen
// ---------------------------------------------------------------------------
module nano_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [31:0]        fetch_pc_r;
  logic [31:0]        fetch_pc_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_s;
  logic [CNT_W-1:0]   remain_s;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_s;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_s;
  logic [31:0]        inst_mem_r [BUF_DEPTH];
  logic [31:0]        pc_mem_r   [BUF_DEPTH];

  logic               xfer_s;
  logic               hold_s;
  logic               pop_s;
  logic               push_s;
  logic               flush_s;
  logic               redir_s;
  logic               misalign_s;
  logic               err_s;
  logic               req_s;
  logic [31:0]        addr_s;
  logic               valid_s;
  logic [31:0]        inst_s;
  logic [31:0]        inst_pc_s;

  // Handshake decode shared by the sequencing and FIFO logic.
  always_comb begin
    xfer_s     = o_imem_req & i_imem_ack;
    hold_s     = o_imem_req & ~i_imem_ack;
    pop_s      = o_inst_valid & i_inst_ready;
    redir_s    = i_redirect & (state_r != ST_HALT);
    misalign_s = (i_redirect_pc[1:0] != 2'b00);
  end

  // Next sequencer state, fetch PC, push and flush decisions.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    push_s     = 1'b0;
    flush_s    = 1'b0;
    err_s      = o_fetch_err;
    case (state_r)
      ST_FETCH: begin
        if (redir_s) begin
          flush_s = 1'b1;
          if (misalign_s) begin
            err_s   = 1'b1;
            state_s = ST_HALT;
          end else begin
            fetch_pc_s = i_redirect_pc;
            // An unacked request must still complete before the new stream starts.
            state_s    = hold_s ? ST_DRAIN : ST_FETCH;
          end
        end else if (xfer_s) begin
          push_s     = 1'b1;
          fetch_pc_s = fetch_pc_r + 32'd4;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (redir_s) begin
          flush_s = 1'b1;
          if (misalign_s) begin
            err_s   = 1'b1;
            state_s = ST_HALT;
          end else begin
            fetch_pc_s = i_redirect_pc;
            // If the squashed request completes now there is nothing left to drain.
            state_s    = xfer_s ? ST_FETCH : ST_DRAIN;
          end
        end else if (xfer_s) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_HALT;
        flush_s = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping and the registered-output next values (head, request).
  always_comb begin
    if (flush_s) begin
      count_s  = '0;
      rd_ptr_s = '0;
      wr_ptr_s = '0;
    end else begin
      count_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      rd_ptr_s = rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_s = wr_ptr_r + PTR_W'(push_s);
    end
    remain_s = count_r - CNT_W'(pop_s);

    // When the FIFO would otherwise be empty the pushed word becomes the head directly.
    if (count_s != '0) begin
      valid_s = 1'b1;
      if (remain_s == '0) begin
        inst_s    = i_imem_rdata;
        inst_pc_s = fetch_pc_r;
      end else begin
        inst_s    = inst_mem_r[rd_ptr_s];
        inst_pc_s = pc_mem_r[rd_ptr_s];
      end
    end else begin
      valid_s   = 1'b0;
      inst_s    = 32'h0000_0000;
      inst_pc_s = 32'h0000_0000;
    end

    // Credit uses the post-edge count so a slot is never over-committed.
    case (state_s)
      ST_FETCH: req_s = hold_s | (count_s < DEPTH_C);
      ST_DRAIN: req_s = 1'b1;
      ST_HALT:  req_s = hold_s;
      default:  req_s = 1'b0;
    endcase
    addr_s = hold_s ? o_imem_addr : fetch_pc_s;
  end

  // State, FIFO storage and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r      <= ST_FETCH;
      fetch_pc_r   <= RESET_PC;
      count_r      <= '0;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      o_imem_req   <= 1'b0;
      o_imem_addr  <= RESET_PC;
      o_inst_valid <= 1'b0;
      o_inst       <= 32'h0000_0000;
      o_inst_pc    <= 32'h0000_0000;
      o_fetch_err  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        inst_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      count_r      <= count_s;
      rd_ptr_r     <= rd_ptr_s;
      wr_ptr_r     <= wr_ptr_s;
      o_imem_req   <= req_s;
      o_imem_addr  <= addr_s;
      o_inst_valid <= valid_s;
      o_inst       <= inst_s;
      o_inst_pc    <= inst_pc_s;
      o_fetch_err  <= err_s;
      if (push_s) begin
        inst_mem_r[wr_ptr_r] <= i_imem_rdata;
        pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
      end
    end
  end

endmodule

// File: tb/tb_nano_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nano_fetch_ctrl
//   Randomized bench for nano_fetch_ctrl. A reference model tracks the
//   instruction stream decode must see: after reset or an aligned redirect to T
//   the stream is T, T+4, T+8, ... and a fetch is only delivered if it is the
//   stream's next address and was not completed in a redirect cycle. Expected
//   {pc, word} pairs are queued; a separate monitor pops and compares on every
//   decode transfer and checks protocol and sticky-error behaviour.
// ---------------------------------------------------------------------------
module tb_nano_fetch_ctrl;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  nano_fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_inst_ready(inst_ready),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_fetch_err(fetch_err)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] word; } item_t;

  item_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          decoded = 0;
  int          seg = 0;
  logic [31:0] model_next = RESET_PC;
  bit          model_halt = 1'b0;
  bit          model_err = 1'b0;
  bit          rst_seen = 1'b1;

  // Memory contents as a fixed function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: follows resets, redirects and completed fetches.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        exp_q.delete();
        model_next = RESET_PC;
        model_halt = 1'b0;
        model_err  = 1'b0;
        rst_seen   = 1'b1;
      end else begin
        rst_seen = 1'b0;
        if (redirect && !model_halt) begin
          exp_q.delete();
          if (redirect_pc[1:0] != 2'b00) begin
            model_halt = 1'b1;
            model_err  = 1'b1;
          end else begin
            model_next = redirect_pc;
          end
        end else if (imem_req && imem_ack && !model_halt && imem_addr == model_next) begin
          exp_q.push_back({imem_addr, mem_word(imem_addr)});
          model_next = model_next + 32'd4;
        end
      end
    end
  end

  // Monitor: decode-side scoreboard plus protocol checks.
  initial begin
    item_t       it;
    bit          prev_hold = 1'b0;
    bit          prev_done = 1'b1;
    logic [31:0] prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check("rst_req",   32'(imem_req),   32'd0);
        check("rst_addr",  imem_addr,       RESET_PC);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst",  inst,            32'd0);
        check("rst_pc",    inst_pc,         32'd0);
        check("rst_err",   32'(fetch_err),  32'd0);
      end else begin
        check("valid", 32'(inst_valid), 32'(exp_q.size() != 0));
        check("fetch_err", 32'(fetch_err), 32'(model_err));
        if (prev_hold) begin
          check("req_held",  32'(imem_req), 32'd1);
          check("addr_held", imem_addr, prev_addr);
        end
        if (model_halt && prev_done) check("halt_req", 32'(imem_req), 32'd0);
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_inst: got pc %h with nothing expected at %0t", inst_pc, $time);
          end else begin
            it = exp_q.pop_front();
            check("inst_pc", inst_pc, it.pc);
            check("inst",    inst,    it.word);
            decoded++;
          end
        end
      end
      prev_hold = rst && imem_req && !imem_ack;
      prev_done = !imem_req || imem_ack;
      prev_addr = imem_addr;
    end
  end

  // One cycle of stimulus; acks also appear randomly while no request is up.
  task automatic drive(input int ack_pct, input int ready_pct, input int redir_pct,
                       input int rst_pct, input bit force_redir, input logic [31:0] force_pc);
    @(posedge clk);
    #1;
    rst        = (int'($urandom_range(0, 99)) < rst_pct) ? 1'b0 : 1'b1;
    inst_ready = (int'($urandom_range(0, 99)) < ready_pct);
    if (imem_req) imem_ack = (int'($urandom_range(0, 99)) < ack_pct);
    else          imem_ack = (int'($urandom_range(0, 99)) < 20);
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
    end else if (int'($urandom_range(0, 99)) < redir_pct) begin
      seg++;
      redirect    = 1'b1;
      redirect_pc = (32'(seg) << 16) | {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    end else begin
      redirect    = 1'b0;
      redirect_pc = $urandom;
    end
  endtask

  int phase_cfg [5][4] = '{'{70, 70, 3, 0}, '{30, 90, 2, 0}, '{90, 30, 4, 0},
                           '{50, 50, 3, 2}, '{100, 100, 1, 0}};
  int start_cnt;

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Streaming: ack and ready every cycle gives one instruction per cycle.
    start_cnt = decoded;
    repeat (30) drive(100, 100, 0, 0, 1'b0, 32'h0);
    @(negedge clk); #2;
    check("throughput", 32'(decoded - start_cnt >= 27), 32'd1);

    // Decode stalled: exactly BUF_DEPTH words buffered, then no request.
    repeat (10) drive(100, 0, 0, 0, 1'b0, 32'h0);
    @(negedge clk); #2;
    check("stall_req",   32'(imem_req),   32'd0);
    check("stall_valid", 32'(inst_valid), 32'd1);
    repeat (10) drive(100, 100, 0, 0, 1'b0, 32'h0);

    // Redirect to 0x100 while a slow fetch is in flight.
    repeat (2) drive(0, 100, 0, 0, 1'b0, 32'h0);
    drive(0, 100, 0, 0, 1'b1, 32'h0000_0100);
    repeat (2) drive(0, 100, 0, 0, 1'b0, 32'h0);
    repeat (10) drive(100, 100, 0, 0, 1'b0, 32'h0);

    // Redirect to 0x200 coinciding with an ack.
    repeat (2) drive(0, 100, 0, 0, 1'b0, 32'h0);
    drive(100, 100, 0, 0, 1'b1, 32'h0000_0200);
    repeat (10) drive(100, 100, 0, 0, 1'b0, 32'h0);

    // Fetch PC wraps past the top of the address space.
    drive(100, 100, 0, 0, 1'b1, 32'hFFFF_FFF0);
    repeat (20) drive(100, 100, 0, 0, 1'b0, 32'h0);

    // Randomized traffic, including sporadic resets in one phase.
    for (int p = 0; p < 5; p++) begin
      repeat (300) drive(phase_cfg[p][0], phase_cfg[p][1], phase_cfg[p][2], phase_cfg[p][3],
                         1'b0, 32'h0);
    end

    // Misaligned redirect with a request in flight, then halt until reset.
    repeat (3) drive(100, 100, 0, 0, 1'b0, 32'h0);
    drive(0, 100, 0, 0, 1'b0, 32'h0);
    drive(0, 100, 0, 0, 1'b1, 32'h0000_0102);
    repeat (2) drive(0, 100, 0, 0, 1'b0, 32'h0);
    @(negedge clk); #2;
    check("halt_err",   32'(fetch_err),  32'd1);
    check("halt_valid", 32'(inst_valid), 32'd0);
    repeat (15) drive(100, 100, 30, 0, 1'b0, 32'h0);
    @(negedge clk); #2;
    check("halt_idle", 32'(imem_req), 32'd0);
    drive(100, 100, 0, 100, 1'b0, 32'h0);
    start_cnt = decoded;
    repeat (20) drive(100, 100, 0, 0, 1'b0, 32'h0);
    @(negedge clk); #2;
    check("restart", 32'(decoded - start_cnt >= 15), 32'd1);

    // Reset with a request outstanding.
    repeat (3) drive(0, 100, 0, 0, 1'b0, 32'h0);
    drive(0, 100, 0, 100, 1'b0, 32'h0);
    repeat (10) drive(100, 100, 0, 0, 1'b0, 32'h0);

    @(negedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
